sysid_regs: RTL
===============

# sysid_regs

Parametrised system-identification register block on an Avalon-MM control slave. It replaces the fixed two-word ID/timestamp responder with a registered eight-word map. The map adds a version word, a scratch register, a capability word, and an optional 64-bit uptime counter with atomic high-word snapshot. It sits on the Nios II data master's interconnect and is probed by software at boot to confirm it is talking to the expected FPGA image.

## Interface
Parameters:
- SYSTEM_ID, 32'h0000_0000: value returned at word 0.
- TIMESTAMP, 32'h0000_0000: build time (Unix seconds) returned at word 1.
- VERSION, 32'h0001_0000: image version {major[15:0], minor[15:0]}, word 2.
- SCRATCH_RESET, 32'h0000_0000: reset value of the scratch register.
- TICK_DIV, 1: clocks per uptime increment. Legal range is 1..2^16.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe, one cycle per transfer
- write  in  1  write strobe, one cycle per transfer
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse qualifying readdata

## Operation
Register map (word address: access, content):
- 0 RO: SYSTEM_ID.
- 1 RO: TIMESTAMP.
- 2 RO: VERSION.
- 3 RW: SCRATCH. Only lanes with byteenable set are written.
- 4 RW: UPTIME_LO.
  - A read returns counter[31:0] and, in the same cycle, loads counter[63:32] into HI_SHADOW.
  - Any write (data ignored) clears the counter, prescaler and HI_SHADOW.
- 5 RO: HI_SHADOW. A read does not disturb it.
- 6 RO: CAPS = {TICK_DIV-1 [31:16], 15'b0, uptime_present [0]}.
- 7 RO: reads 0.
- Writes to RO addresses are ignored.

Uptime counter:
- Prescaler counts 0..TICK_DIV-1.
- The 64-bit counter increments in the cycle the prescaler wraps to 0.
- When TICK_DIV=1 the counter increments every clock.
- The counter wraps from 2^64-1 to 0 silently.

Protocol rules:
- read and write asserted together: the write executes, no read occurs, and readdatavalid stays low.
- Read of UPTIME_LO in the same cycle as an increment: return and snapshot the pre-increment value. LO and shadow are always consistent.
- Reset mid-operation: any pending readdatavalid is dropped and all state returns to its reset value.

## Timing
- Read latency is 1. readdata and readdatavalid are registered from the read cycle.
- readdatavalid is high for exactly one cycle per accepted read.
- readdata holds its last value when readdatavalid is low.
- Back-to-back reads are supported, one per clock.
- Writes take effect at the clock edge of the write cycle. A read in the next cycle returns the new value.
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - SCRATCH = SCRATCH_RESET.
  - counter = 0, prescaler = 0, HI_SHADOW = 0.

## Configuration
- SYSID_UPTIME_EN defined: prescaler, 64-bit counter and HI_SHADOW are built. CAPS[0] = 1.
- Not defined: no counter logic. Addresses 4 and 5 read 0, writes to them are ignored, and CAPS[0] = 0. CAPS[31:16] still reports TICK_DIV-1.
- The address map, latency and all other registers are identical in both builds.

## Structure
- Shared package sysid_pkg holds:
  - word-address constants (ADDR_ID .. ADDR_RSVD)
  - the CAPS bit positions
  - the data-width constant
- One sub-module, sysid_uptime: prescaler plus 64-bit counter with clear and snapshot inputs. It is instantiated only under SYSID_UPTIME_EN.
- The top level contains the decode, scratch, read mux and readdatavalid register.

## Test plan
- Reset, then read words 0–2 with SYSTEM_ID=32'h61F7_6A11, TIMESTAMP=32'h4C34_A7B5 -> 32'h61F7_6A11, 32'h4C34_A7B5, VERSION. Each has readdatavalid exactly one cycle after read.
- Write 32'hDEAD_BEEF to word 3 with byteenable=4'b0101 over SCRATCH_RESET=0 -> read returns 32'h00AD_00EF. Read during reset assertion -> readdatavalid stays 0.
- TICK_DIV=4:
  - Clear via write to word 4, wait 40 clocks, read word 4 -> 10 (±1 per clear/read edge alignment, checked exactly by a model).
  - CAPS reads 32'h0003_0001.
- Snapshot and wrap: force counter to 64'h0000_0001_FFFF_FFFF one tick before wrap, read LO on the increment cycle -> LO = 32'hFFFF_FFFF, then HI = 1. A later HI read stays 1 after the counter passes 2^33.
- Simultaneous read+write to word 3 -> scratch updated, no readdatavalid. Back-to-back reads of 0,1,2,6 -> four consecutive valid pulses in order.
- Build without SYSID_UPTIME_EN -> words 4, 5 read 0, CAPS[0] = 0, and a write to word 4 has no effect.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared constants for the system-identification register block.
// Optional uptime counter is built when SYSID_UPTIME_EN is defined.
package sysid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned PRE_W  = 16;

  // Word addresses
  localparam logic [ADDR_W-1:0] ADDR_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_VER     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_UP_LO   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_UP_HI   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_CAPS    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = ADDR_W'(7);

  // CAPS bit positions
  localparam int unsigned CAPS_UPTIME_BIT = 0;
  localparam int unsigned CAPS_DIV_LSB    = 16;
  localparam int unsigned CAPS_DIV_MSB    = 31;

  // Registered read response
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } sysid_rsp_t;

  // Merge write data into an existing word on the enabled byte lanes
  function automatic logic [DATA_W-1:0] apply_be(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_uptime.sv
// Prescaled 64-bit uptime counter with clear and atomic high-word snapshot.
// Instantiated by sysid_regs only when SYSID_UPTIME_EN is defined.
module sysid_uptime
  import sysid_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              snapshot,
  output logic [DATA_W-1:0] count_lo,
  output logic [DATA_W-1:0] hi_shadow
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] count_q;
  logic             wrap_c;

  assign wrap_c   = (pre_q == PRE_MAX);
  assign count_lo = count_q[DATA_W-1:0];

  // Prescaler and counter; increment lands on the prescaler wrap edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      pre_q   <= '0;
      count_q <= '0;
    end else begin
      pre_q <= wrap_c ? '0 : pre_q + PRE_W'(1);
      if (wrap_c) count_q <= count_q + CNT_W'(1);
    end
  end

  // Shadow captures the pre-increment high word alongside the LO read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_shadow <= '0;
    end else if (clear) begin
      hi_shadow <= '0;
    end else if (snapshot) begin
      hi_shadow <= count_q[CNT_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// System-identification register block, Avalon-MM slave, read latency 1.
// Define SYSID_UPTIME_EN to build the 64-bit uptime counter at words 4/5.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [31:0] VERSION       = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam logic [15:0] DIV_M1 = 16'(TICK_DIV - 1);

  logic              rd_c;
  logic              wr_c;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] caps_c;
  logic [DATA_W-1:0] up_lo;
  logic [DATA_W-1:0] up_hi;
  logic              up_present;
  sysid_rsp_t        rsp_q;

  // A write always wins; a simultaneous read is dropped
  assign wr_c = write;
  assign rd_c = read & ~write;

`ifdef SYSID_UPTIME_EN
  assign up_present = 1'b1;

  sysid_uptime #(
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (wr_c && (address == ADDR_UP_LO)),
    .snapshot  (rd_c && (address == ADDR_UP_LO)),
    .count_lo  (up_lo),
    .hi_shadow (up_hi)
  );
`else
  assign up_present = 1'b0;
  assign up_lo      = '0;
  assign up_hi      = '0;
`endif

  // Capability word
  always_comb begin
    caps_c                              = '0;
    caps_c[CAPS_DIV_MSB:CAPS_DIV_LSB]   = DIV_M1;
    caps_c[CAPS_UPTIME_BIT]             = up_present;
  end

  // Scratch register with byte-lane writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_RESET;
    end else if (wr_c && (address == ADDR_SCRATCH)) begin
      scratch_q <= apply_be(scratch_q, writedata, byteenable);
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    unique case (address)
      ADDR_ID:      rdata_c = SYSTEM_ID;
      ADDR_TS:      rdata_c = TIMESTAMP;
      ADDR_VER:     rdata_c = VERSION;
      ADDR_SCRATCH: rdata_c = scratch_q;
      ADDR_UP_LO:   rdata_c = up_lo;
      ADDR_UP_HI:   rdata_c = up_hi;
      ADDR_CAPS:    rdata_c = caps_c;
      ADDR_RSVD:    rdata_c = '0;
      default:      rdata_c = '0;
    endcase
  end

  // Registered response; data holds while no read is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= rd_c;
      if (rd_c) rsp_q.data <= rdata_c;
    end
  end

  assign readdata      = rsp_q.data;
  assign readdatavalid = rsp_q.valid;

endmodule
